// File: rtl/spi_master_reg_pkg.sv
// Shared widths, FSM encodings and helpers for the register-access SPI initiator.
package spi_master_reg_pkg;

    localparam int FPGA_REG_AWIDTH = 8;
    localparam int FPGA_REG_DWIDTH = 16;
    localparam int FPGA_REG_FWIDTH = FPGA_REG_AWIDTH + FPGA_REG_DWIDTH;

    // FSM encodings kept as plain constants so legacy tools can read them
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_master_reg_if.sv
// Request/response handshake between a host and the SPI register initiator.
interface spi_master_reg_if;
    import spi_master_reg_pkg::*;

    logic                       p_in_start;
    logic                       p_in_rd;
    logic [FPGA_REG_AWIDTH-1:0] p_in_addr;
    logic [FPGA_REG_DWIDTH-1:0] p_in_wdata;
    logic                       p_out_busy;
    logic                       p_out_done;
    logic [FPGA_REG_DWIDTH-1:0] p_out_rdata;

    // host side issues requests
    modport master (
        output p_in_start, p_in_rd, p_in_addr, p_in_wdata,
        input  p_out_busy, p_out_done, p_out_rdata
    );

    // initiator side serves them
    modport slave (
        input  p_in_start, p_in_rd, p_in_addr, p_in_wdata,
        output p_out_busy, p_out_done, p_out_rdata
    );

endinterface

// File: rtl/spi_master_reg_sclk_gen.sv
// SCLK phase timer: counts cycles inside the current SCLK level and strobes
// the last cycle of a low or high phase.
module spi_master_reg_sclk_gen #(
    parameter int G_CLK_DIV = 2,
    parameter int CW        = 2
) (
    input  logic p_in_clk,
    input  logic p_in_rst_n,
    input  logic run,       // FSM is in a shift phase
    input  logic hi,        // current phase is SCLK high
    output logic lo_end,
    output logic hi_end
);

    logic [CW-1:0] cnt_q;
    logic          last;

    assign last   = (cnt_q == CW'(G_CLK_DIV - 1));
    assign lo_end = run && !hi && last;
    assign hi_end = run &&  hi && last;

    // restart the count at every phase boundary and whenever shifting is idle
    always_ff @(posedge p_in_clk) begin
        if (!p_in_rst_n || !run || last)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/spi_master_reg.sv
// Register-access SPI initiator (mode 0): 8-bit address + 16-bit data frame,
// MSB first, behind a start/done handshake. All outputs are registered.
module spi_master_reg
    import spi_master_reg_pkg::*;
#(
    parameter int G_CLK_DIV  = 2,
    parameter int G_CS_SETUP = 2,
    parameter int G_CS_HOLD  = 2,
    parameter int G_CS_GAP   = 2
) (
    input  logic                  p_in_clk,
    input  logic                  p_in_rst_n,
    spi_master_reg_if.slave       bus,
    output logic                  spi_cs_o,
    output logic                  spi_clk_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);

    localparam int CW = $clog2(max4(G_CLK_DIV, G_CS_SETUP, G_CS_HOLD, G_CS_GAP)) + 1;

    logic [2:0]                 state_q;
    logic [CW-1:0]              cnt_q;
    logic [4:0]                 bit_q;
    logic [4:0]                 bit_nx;
    logic [FPGA_REG_FWIDTH-1:0] frame_q;
    logic [FPGA_REG_DWIDTH-1:0] rx_q;     // address bits shift out the top
    logic [FPGA_REG_DWIDTH-1:0] rdata_q;
    logic                       rd_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       run;
    logic                       hi;
    logic                       lo_end;
    logic                       hi_end;

    assign run    = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);
    assign hi     = (state_q == ST_SHIFT_HI);
    assign bit_nx = bit_q - 5'd1;

    assign bus.p_out_busy  = busy_q;
    assign bus.p_out_done  = done_q;
    assign bus.p_out_rdata = rdata_q;

    spi_master_reg_sclk_gen #(
        .G_CLK_DIV (G_CLK_DIV),
        .CW        (CW)
    ) u_sclk_gen (
        .p_in_clk   (p_in_clk),
        .p_in_rst_n (p_in_rst_n),
        .run        (run),
        .hi         (hi),
        .lo_end     (lo_end),
        .hi_end     (hi_end)
    );

    // frame FSM: latches the request, walks CS/SCLK/MOSI and collects MISO
    always_ff @(posedge p_in_clk) begin
        if (!p_in_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            frame_q    <= '0;
            rx_q       <= '0;
            rdata_q    <= '0;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            spi_cs_o   <= 1'b1;
            spi_clk_o  <= 1'b0;
            spi_mosi_o <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.p_in_start) begin
                        frame_q    <= bus.p_in_rd ? {bus.p_in_addr, 16'h0000}
                                                  : {bus.p_in_addr, bus.p_in_wdata};
                        rd_q       <= bus.p_in_rd;
                        busy_q     <= 1'b1;
                        spi_cs_o   <= 1'b0;
                        spi_clk_o  <= 1'b0;
                        spi_mosi_o <= bus.p_in_addr[FPGA_REG_AWIDTH-1];
                        cnt_q      <= '0;
                        bit_q      <= 5'(FPGA_REG_FWIDTH - 1);
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == CW'(G_CS_SETUP - 1)) begin
                        spi_mosi_o <= frame_q[bit_q];
                        state_q    <= ST_SHIFT_LO;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SHIFT_LO: begin
                    if (lo_end) begin
                        spi_clk_o <= 1'b1;
                        state_q   <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (hi_end) begin
                        rx_q      <= {rx_q[FPGA_REG_DWIDTH-2:0], spi_miso_i};
                        spi_clk_o <= 1'b0;
                        if (bit_q == 5'd0) begin
                            cnt_q   <= '0;
                            state_q <= ST_HOLD;
                        end else begin
                            bit_q      <= bit_nx;
                            spi_mosi_o <= frame_q[bit_nx];
                            state_q    <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == CW'(G_CS_HOLD - 1)) begin
                        spi_cs_o <= 1'b1;
                        done_q   <= 1'b1;
                        if (rd_q) rdata_q <= rx_q;
                        cnt_q    <= '0;
                        state_q  <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CW'(G_CS_GAP - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_reg.sv
// Directed bench: default, fast (DIV=1) and slow (DIV=7) instances with a
// mode-0 responder model and a negedge waveform monitor per instance.
module tb_spi_master_reg;

    localparam int DIVS [3] = '{2, 1, 7};
    localparam int SUS  [3] = '{2, 1, 5};
    localparam int HOS  [3] = '{2, 1, 5};
    localparam int GPS  [3] = '{2, 1, 5};
    // hand-computed: CS-fall-to-done and CS-fall-to-first-rise distances
    localparam int LENS [3] = '{100, 50, 346};
    localparam int FRS  [3] = '{4, 2, 12};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n, start, rd, cs, sclk, mosi, miso, busy, done, loop;
    logic [7:0]  addr [3];
    logic [15:0] wdata [3];
    logic [15:0] rdata [3];
    logic [15:0] resp_data [3];
    logic [23:0] tx [3];
    logic [23:0] cap [3];
    logic [23:0] frm_cap [3];
    logic [15:0] frm_rdata [3];
    logic [2:0]  p_cs, p_sclk, p_busy;
    int csfall_n [3], csrise_n [3], chg_n [3], done_n [3], rises [3], ph_bad [3];
    int frise [3], gap_run [3], done_total [3], busy_lag [3];
    int frm_rises [3], frm_len [3], frm_bad [3];
    int n;
    int ncmp = 0;
    int nerr = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spi_master_reg_if bus ();
        assign bus.p_in_start = start[g];
        assign bus.p_in_rd    = rd[g];
        assign bus.p_in_addr  = addr[g];
        assign bus.p_in_wdata = wdata[g];
        assign busy[g]  = bus.p_out_busy;
        assign done[g]  = bus.p_out_done;
        assign rdata[g] = bus.p_out_rdata;
        spi_master_reg #(
            .G_CLK_DIV  (DIVS[g]),
            .G_CS_SETUP (SUS[g]),
            .G_CS_HOLD  (HOS[g]),
            .G_CS_GAP   (GPS[g])
        ) u_dut (
            .p_in_clk   (clk),
            .p_in_rst_n (rst_n[g]),
            .bus        (bus.slave),
            .spi_cs_o   (cs[g]),
            .spi_clk_o  (sclk[g]),
            .spi_mosi_o (mosi[g]),
            .spi_miso_i (miso[g])
        );
    end

    // responder drives its shift register MSB, or echoes MOSI in loopback
    always_comb begin
        miso = '0;
        for (int i = 0; i < 3; i++) miso[i] = loop[i] ? mosi[i] : tx[i][23];
    end

    // waveform monitor and responder shifting, away from the active edge
    always @(negedge clk) begin
        n = n + 1;
        for (int i = 0; i < 3; i++) begin
            if (p_cs[i] && !cs[i]) begin
                csfall_n[i] = n; gap_run[i] = n - csrise_n[i];
                rises[i] = 0; cap[i] = '0; ph_bad[i] = 0; chg_n[i] = n;
                tx[i] = {8'h00, resp_data[i]};
            end
            if (!p_cs[i] && cs[i]) csrise_n[i] = n;
            if (!p_sclk[i] && sclk[i]) begin
                if (rises[i] == 0) frise[i] = n - csfall_n[i];
                else if (n - chg_n[i] != DIVS[i]) ph_bad[i]++;
                rises[i]++; cap[i] = {cap[i][22:0], mosi[i]}; chg_n[i] = n;
            end
            if (p_sclk[i] && !sclk[i]) begin
                if (n - chg_n[i] != DIVS[i]) ph_bad[i]++;
                chg_n[i] = n; tx[i] = {tx[i][22:0], 1'b0};
            end
            if (done[i] === 1'b1) begin
                done_total[i]++; done_n[i] = n;
                frm_cap[i] = cap[i]; frm_rises[i] = rises[i];
                frm_len[i] = n - csfall_n[i]; frm_rdata[i] = rdata[i];
                frm_bad[i] = ph_bad[i];
            end
            if (p_busy[i] === 1'b1 && busy[i] === 1'b0) busy_lag[i] = n - done_n[i];
        end
        p_cs = cs; p_sclk = sclk; p_busy = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int g);
        int k;
        k = 0;
        while (busy[g] !== 1'b0 && k < 1000) begin step(); k++; end
        chk("tmo_idle", 32'(k < 1000), 32'd1);
    endtask

    task automatic wait_done(input int g, input int base);
        int k;
        k = 0;
        while (done_total[g] == base && k < 2000) begin step(); k++; end
        chk("tmo_done", 32'(k < 2000), 32'd1);
    endtask

    // one frame; request inputs are scrambled right after acceptance
    task automatic do_frame(input int g, input logic r, input logic [7:0] a, input logic [15:0] d);
        int base;
        wait_idle(g);
        base = done_total[g];
        rd[g] = r; addr[g] = a; wdata[g] = d; start[g] = 1'b1;
        step();
        start[g] = 1'b0; rd[g] = ~r; addr[g] = ~a; wdata[g] = ~d;
        chk("busy_after_start", 32'(busy[g]), 32'd1);
        wait_done(g, base);
        wait_idle(g);
    endtask

    task automatic b2b(input int g, input int exp_gap);
        int base, k;
        wait_idle(g);
        base = done_total[g];
        rd[g] = 1'b0; addr[g] = 8'h55; wdata[g] = 16'h0F0F; start[g] = 1'b1;
        k = 0;
        while (done_total[g] < base + 3 && k < 5000) begin step(); k++; end
        start[g] = 1'b0;
        chk("b2b_tmo", 32'(k < 5000), 32'd1);
        wait_idle(g);
        repeat (20) step();
        chk("b2b_frames", 32'(done_total[g] - base), 32'd3);
        chk("b2b_gap", 32'(gap_run[g]), 32'(exp_gap));
        chk("b2b_mosi", frm_cap[g], 32'h550F0F);
    endtask

    initial begin
        int base, k;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; wdata[i] = '0; resp_data[i] = '0; tx[i] = '0; cap[i] = '0;
            csfall_n[i] = 0; csrise_n[i] = 0; chg_n[i] = 0; done_n[i] = 0; rises[i] = 0;
            ph_bad[i] = 0; frise[i] = 0; gap_run[i] = 0; done_total[i] = 0; busy_lag[i] = 0;
        end
        p_cs = '1; p_sclk = '0; p_busy = '0;
        rst_n = '0; start = '0; rd = '0; loop = '0;
        repeat (3) step();
        chk("rst_cs", 32'(cs), 32'h7);
        chk("rst_sclk", 32'(sclk), 32'h0);
        chk("rst_mosi", 32'(mosi), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rdata", rdata[0], 32'h0);
        rst_n = '1;
        step();

        // default instance: write, read, write
        resp_data[0] = 16'h5A5A;
        do_frame(0, 1'b0, 8'h12, 16'hA55A);
        chk("w_mosi", frm_cap[0], 32'h12A55A);
        chk("w_rises", 32'(frm_rises[0]), 32'd24);
        chk("w_len", 32'(frm_len[0]), 32'd100);
        chk("w_first_rise", 32'(frise[0]), 32'd4);
        chk("w_phase", 32'(frm_bad[0]), 32'd0);
        chk("w_busy_lag", 32'(busy_lag[0]), 32'd2);
        chk("w_rdata", rdata[0], 32'h0);

        resp_data[0] = 16'hBEEF;
        do_frame(0, 1'b1, 8'h81, 16'hFFFF);
        chk("r_mosi", frm_cap[0], 32'h810000);
        chk("r_rdata_done", frm_rdata[0], 32'hBEEF);
        chk("r_rises", 32'(frm_rises[0]), 32'd24);

        resp_data[0] = 16'h5555;
        do_frame(0, 1'b0, 8'h34, 16'h00FF);
        chk("w2_mosi", frm_cap[0], 32'h3400FF);
        chk("w2_rdata_kept", rdata[0], 32'hBEEF);

        // start held high: one IDLE acceptance cycle follows the gap
        b2b(0, GPS[0] + 1);

        // starts pulsed while busy are dropped
        base = done_total[0];
        rd[0] = 1'b0; addr[0] = 8'h66; wdata[0] = 16'h1111; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (10) step();
        start[0] = 1'b1; step(); start[0] = 1'b0;
        repeat (30) step();
        start[0] = 1'b1; step(); start[0] = 1'b0;
        wait_done(0, base);
        wait_idle(0);
        repeat (10) step();
        chk("busy_ignore", 32'(done_total[0] - base), 32'd1);
        chk("busy_ignore_mosi", frm_cap[0], 32'h661111);

        // reset during bit 10 (MOSI is 1 there)
        wait_idle(0);
        rd[0] = 1'b0; addr[0] = 8'h12; wdata[0] = 16'hA55A; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        k = 0;
        while (rises[0] < 14 && k < 500) begin step(); k++; end
        chk("mid_tmo", 32'(k < 500), 32'd1);
        chk("mid_mosi_pre", 32'(mosi[0]), 32'd1);
        base = done_total[0];
        rst_n[0] = 1'b0;
        step();
        chk("mid_cs", 32'(cs[0]), 32'd1);
        chk("mid_sclk", 32'(sclk[0]), 32'd0);
        chk("mid_mosi", 32'(mosi[0]), 32'd0);
        chk("mid_busy", 32'(busy[0]), 32'd0);
        chk("mid_done", 32'(done[0]), 32'd0);
        chk("mid_rdata", rdata[0], 32'h0);
        rst_n[0] = 1'b1;
        repeat (150) step();
        chk("mid_no_done", 32'(done_total[0] - base), 32'd0);
        resp_data[0] = 16'h1357;
        do_frame(0, 1'b1, 8'h81, 16'h0000);
        chk("post_mosi", frm_cap[0], 32'h810000);
        chk("post_rdata", rdata[0], 32'h1357);
        chk("post_len", 32'(frm_len[0]), 32'd100);

        // extreme parameter sets
        for (int i = 1; i < 3; i++) begin
            resp_data[i] = 16'h0000;
            do_frame(i, 1'b0, 8'h12, 16'hA55A);
            chk("x_w_mosi", frm_cap[i], 32'h12A55A);
            chk("x_w_rises", 32'(frm_rises[i]), 32'd24);
            chk("x_w_len", 32'(frm_len[i]), 32'(LENS[i]));
            chk("x_w_first_rise", 32'(frise[i]), 32'(FRS[i]));
            chk("x_w_phase", 32'(frm_bad[i]), 32'd0);
            chk("x_w_busy_lag", 32'(busy_lag[i]), 32'(GPS[i]));
            resp_data[i] = 16'hBEEF;
            do_frame(i, 1'b1, 8'h81, 16'h0000);
            chk("x_r_rdata", rdata[i], 32'hBEEF);
            loop[i] = 1'b1;
            do_frame(i, 1'b0, 8'h12, 16'h1234);
            chk("x_lb_w_mosi", frm_cap[i], 32'h121234);
            chk("x_lb_w_rdata", rdata[i], 32'hBEEF);
            do_frame(i, 1'b1, 8'h81, 16'hFFFF);
            chk("x_lb_r_rdata", rdata[i], 32'h0000);
            loop[i] = 1'b0;
        end
        b2b(1, GPS[1] + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
